// File: rtl/afifo_pkg.sv
// Shared types and default parameters for the async-FIFO read-side packer.
package afifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int DEF_DSIZE = 8;
  localparam int DEF_LANES = 4;
  localparam int DEF_TMO   = 16;

  // Lane counter must reach LANES itself, so it needs one bit more than the lane index.
  function automatic int cnt_width(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/afifo_out_reg.sv
// Output holding register with valid/ready handshake; payload is held while stalled.
module afifo_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             ready,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             free
);

  assign free = !valid || ready;

  // Capture a new word on load; otherwise drop valid once the consumer has taken the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/afifo_rd_pack.sv
// Pops entries from an async FIFO read port and packs LANES of them into one output word,
// emitting partial words on flush or after an idle timeout.
module afifo_rd_pack
  import afifo_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int LANES = DEF_LANES,
  parameter int TMO   = DEF_TMO
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DSIZE*LANES-1:0] m_data,
  output logic [LANES-1:0]       m_keep
);

  localparam int LW = $clog2(LANES);
  localparam int CW = cnt_width(LANES);
  localparam int TW = $clog2(TMO) + 1;
  // The timer is compared before it increments, so the limit is one below TMO-1.
  localparam logic [TW-1:0] TLIM = TW'((TMO >= 2) ? TMO - 2 : 0);

  state_t                   state, state_nxt;
  logic [CW-1:0]            cnt;
  logic [TW-1:0]            timer;
  logic [DSIZE*LANES-1:0]   word;
  logic [LANES-1:0]         keep_c;
  logic                     pop;
  logic                     load;
  logic                     out_free;
  logic [LANES+DSIZE*LANES-1:0] out_q;

  assign pop = rinc;

  // State register.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: a full word, a flush with data, or an idle timeout all hand the word to SEND.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, FILL: begin
        if (pop && cnt == CW'(LANES - 1))                 state_nxt = SEND;
        else if (flush && (cnt != '0 || pop))             state_nxt = SEND;
        else if (state == FILL && !pop && timer >= TLIM)  state_nxt = SEND;
        else if (pop)                                     state_nxt = FILL;
      end
      SEND:    if (out_free) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: pop only when data is present and no word is waiting; load the output when it frees up.
  always_comb begin
    rinc = !rempty && (state != SEND) && !rrst;
    load = (state == SEND) && out_free;
  end

  // Packing datapath: write each popped entry into the next lane and track idle time.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      cnt   <= '0;
      timer <= '0;
      word  <= '0;
    end else if (load) begin
      cnt   <= '0;
      timer <= '0;
      word  <= '0;
    end else if (state != SEND) begin
      if (pop) begin
        word[int'(cnt[LW-1:0]) * DSIZE +: DSIZE] <= rdata;
        cnt   <= cnt + 1'b1;
        timer <= '0;
      end else if (state == FILL) begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Keep mask covers lanes 0..cnt-1.
  always_comb begin
    keep_c = '0;
    for (int i = 0; i < LANES; i++) keep_c[i] = (cnt > CW'(i));
  end

  afifo_out_reg #(
    .WIDTH(LANES + DSIZE * LANES)
  ) u_out (
    .clk  (rclk),
    .rst  (rrst),
    .load (load),
    .ready(m_ready),
    .din  ({keep_c, word}),
    .valid(m_valid),
    .dout (out_q),
    .free (out_free)
  );

  assign m_keep = out_q[LANES+DSIZE*LANES-1 -: LANES];
  assign m_data = out_q[DSIZE*LANES-1:0];

endmodule
